// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle RV32I integer ops plus RV32M multiplies on an iterative shift-add FSM.
// Define ALU_FAST_MUL_EN to replace the iterative multiplier with a one-cycle combinational product.
module alu_exec_unit #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] aluin1,
    input  logic [XLEN-1:0] aluin2,
    input  logic [3:0]      alu_op,
    input  logic [RD_W-1:0] rd_in,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_result,
    output logic [RD_W-1:0] rd_out,
    output logic            busy
);

    localparam int CNT_W = $clog2(XLEN);

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_SLL    = 4'd2;
    localparam logic [3:0] OP_SLT    = 4'd3;
    localparam logic [3:0] OP_SLTU   = 4'd4;
    localparam logic [3:0] OP_XOR    = 4'd5;
    localparam logic [3:0] OP_SRL    = 4'd6;
    localparam logic [3:0] OP_SRA    = 4'd7;
    localparam logic [3:0] OP_OR     = 4'd8;
    localparam logic [3:0] OP_AND    = 4'd9;
    localparam logic [3:0] OP_PASS   = 4'd10;
    localparam logic [3:0] OP_MUL    = 4'd11;
    localparam logic [3:0] OP_MULH   = 4'd12;
    localparam logic [3:0] OP_MULHSU = 4'd13;
    localparam logic [3:0] OP_MULHU  = 4'd14;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_out_valid;
    logic [XLEN-1:0]       r_result;
    logic [RD_W-1:0]       r_rd_out;
    logic [RD_W-1:0]       r_rd_mul;
    logic [CNT_W-1:0]      r_cnt;
    logic [2*XLEN-1:0]     r_mcand;
    logic [XLEN-1:0]       r_mplier;
    logic [2*XLEN-1:0]     r_acc;
    logic                  r_sign;
    logic                  r_hi;

    logic                  w_out_free;
    logic                  w_accept;
    logic                  w_is_mul;
    logic                  w_iter_mul;
    logic                  w_last;
    logic                  w_single_wr;
    logic                  w_mul_start;
    logic                  w_mul_step;
    logic                  w_mul_fin;
    logic                  w_done_wr;
    logic [CNT_W-1:0]      w_shamt;
    logic [XLEN-1:0]       w_sra;
    logic [XLEN-1:0]       w_alu;
    logic                  w_neg1;
    logic                  w_neg2;
    logic [XLEN-1:0]       w_mag1;
    logic [XLEN-1:0]       w_mag2;
    logic [2*XLEN-1:0]     w_acc_next;
    logic [2*XLEN-1:0]     w_prod;
    logic [XLEN-1:0]       w_prod_sel;
    logic [XLEN-1:0]       w_done_sel;

    // Handshake: a beat moves on a rising edge when valid && ready; in_ready depends only on
    // state, the output register and flush, never on in_valid, so producers may wait on it.
    assign w_out_free = !r_out_valid || out_ready;
    assign in_ready   = (r_state == S_IDLE) && w_out_free && !flush;
    assign w_accept   = in_valid && in_ready;
    assign w_is_mul   = (alu_op >= OP_MUL) && (alu_op <= OP_MULHU);
    assign w_last     = (r_cnt == CNT_W'(XLEN - 1));

    assign w_shamt = aluin2[CNT_W-1:0];
    assign w_sra   = $signed(aluin1) >>> w_shamt;

    // Operands become magnitudes; the product sign is reapplied once at the end.
    assign w_neg1 = ((alu_op == OP_MULH) || (alu_op == OP_MULHSU)) && aluin1[XLEN-1];
    assign w_neg2 = (alu_op == OP_MULH) && aluin2[XLEN-1];
    assign w_mag1 = w_neg1 ? -aluin1 : aluin1;
    assign w_mag2 = w_neg2 ? -aluin2 : aluin2;

`ifdef ALU_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fast_mag;
    logic [2*XLEN-1:0] w_fast_prod;
    assign w_fast_mag  = {{XLEN{1'b0}}, w_mag1} * {{XLEN{1'b0}}, w_mag2};
    assign w_fast_prod = (w_neg1 ^ w_neg2) ? -w_fast_mag : w_fast_mag;
    assign w_iter_mul  = 1'b0;
    assign busy        = 1'b0;
`else
    assign w_iter_mul  = w_is_mul;
    assign busy        = (r_state != S_IDLE);
`endif

    always_comb begin
        w_alu = '0;
        case (alu_op)
            OP_ADD, OP_PASS: w_alu = aluin1 + aluin2;
            OP_SUB:          w_alu = aluin1 - aluin2;
            OP_SLL:          w_alu = aluin1 << w_shamt;
            OP_SLT:          w_alu = {{(XLEN-1){1'b0}}, ($signed(aluin1) < $signed(aluin2))};
            OP_SLTU:         w_alu = {{(XLEN-1){1'b0}}, (aluin1 < aluin2)};
            OP_XOR:          w_alu = aluin1 ^ aluin2;
            OP_SRL:          w_alu = aluin1 >> w_shamt;
            OP_SRA:          w_alu = w_sra;
            OP_OR:           w_alu = aluin1 | aluin2;
            OP_AND:          w_alu = aluin1 & aluin2;
`ifdef ALU_FAST_MUL_EN
            OP_MUL:          w_alu = w_fast_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_alu = w_fast_prod[2*XLEN-1:XLEN];
`endif
            default:         w_alu = '0;
        endcase
    end

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_prod     = r_sign ? -w_acc_next : w_acc_next;
    assign w_prod_sel = r_hi ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];
    assign w_done_sel = r_hi ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_single_wr  = 1'b0;
        w_mul_start  = 1'b0;
        w_mul_step   = 1'b0;
        w_mul_fin    = 1'b0;
        w_done_wr    = 1'b0;
        if (flush) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_iter_mul) begin
                        w_mul_start  = 1'b1;
                        w_state_next = S_MUL;
                    end else if (w_accept) begin
                        w_single_wr  = 1'b1;
                    end
                end
                S_MUL: begin
                    w_mul_step = 1'b1;
                    if (w_last && w_out_free) begin
                        w_mul_fin    = 1'b1;
                        w_state_next = S_IDLE;
                    end else if (w_last) begin
                        w_state_next = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        w_done_wr    = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_rd_out    <= '0;
            r_rd_mul    <= '0;
            r_cnt       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_sign      <= 1'b0;
            r_hi        <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            if (out_ready) r_out_valid <= 1'b0;
            if (w_single_wr) begin
                r_result    <= w_alu;
                r_rd_out    <= rd_in;
                r_out_valid <= 1'b1;
            end
            if (w_mul_start) begin
                r_mcand  <= {{XLEN{1'b0}}, w_mag1};
                r_mplier <= w_mag2;
                r_acc    <= '0;
                r_sign   <= w_neg1 ^ w_neg2;
                r_hi     <= (alu_op != OP_MUL);
                r_rd_mul <= rd_in;
                r_cnt    <= '0;
            end
            if (w_mul_step) begin
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                // On the final step the signed product is parked in r_acc for a DONE stall.
                r_acc    <= w_last ? w_prod : w_acc_next;
                r_cnt    <= w_last ? '0 : r_cnt + 1'b1;
            end
            if (w_mul_fin) begin
                r_result    <= w_prod_sel;
                r_rd_out    <= r_rd_mul;
                r_out_valid <= 1'b1;
            end
            if (w_done_wr) begin
                r_result    <= w_done_sel;
                r_rd_out    <= r_rd_mul;
                r_out_valid <= 1'b1;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign alu_result = r_result;
    assign rd_out     = r_rd_out;

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU, directly downstream of the operand-select mux; consumes aluin1/aluin2 plus a decoded op and produces a registered write-back result.
- Integer ops (RV32I arithmetic/logic/shift/compare, plus pass-through for LUI/AUIPC) complete in one cycle.
- RV32M multiplies (MUL/MULH/MULHSU/MULHU) run on an iterative shift-add FSM.
- Valid/ready handshake on both sides; pipeline flush input.

Parameters:
- XLEN, 32, operand/result width.
- RD_W, 5, destination register tag width.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- in_valid  input  1  operands/op valid
- in_ready  output  1  unit can accept this cycle
- aluin1  input  XLEN  operand 1 from mux
- aluin2  input  XLEN  operand 2 from mux
- alu_op  input  4  operation code
- rd_in  input  RD_W  destination tag, carried to output
- flush  input  1  kill in-flight op and pending result
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- alu_result  output  XLEN  result
- rd_out  output  RD_W  tag of result
- busy  output  1  multiply in progress

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high; sampled on rising edge.
- Reset values: out_valid=0, alu_result=0, rd_out=0, busy=0, state=IDLE, iteration counter=0.
- alu_op encoding:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - 10 PASS (result=aluin1+aluin2, for LUI/AUIPC).
  - 11 MUL, 12 MULH, 13 MULHSU, 14 MULHU.
  - 15 reserved: result 0, single-cycle.
- Width rules:
  - Shifts use aluin2[4:0] only.
  - SLT/SLTU return 0 or 1.
  - All arithmetic wraps mod 2^XLEN.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- Accept occurs on a rising edge with in_valid && in_ready.
- Single-cycle op accepted at edge N:
  - alu_result/rd_out registered and out_valid=1 from edge N.
  - Latency 1.
  - Back-to-back accepts allowed when out_ready=1.
- Multiply op accepted at edge N:
  - State goes IDLE->MUL, busy=1.
  - Operands latched as magnitudes: aluin1 signed for MULH/MULHSU; aluin2 signed for MULH only.
  - Result sign flag latched.
  - One multiplier bit processed per edge into a 2*XLEN accumulator; counter 0..XLEN-1.
  - On the edge where counter==XLEN-1: product negated if sign flag set; low half (MUL) or high half (MULH*) written to alu_result; out_valid=1; state->IDLE; busy=0.
  - First result visible XLEN cycles after the accept edge.
- Output hold: while out_valid && !out_ready, alu_result/rd_out remain stable and in_ready=0.
  - A multiply already in MUL state continues to run.
  - If it reaches completion while the output is still held, it stalls in a DONE state (busy=1) until out_ready, then writes the output.
- Output drain: out_valid cleared on an edge with out_ready=1 unless a new result is written the same edge.
- Flush (priority below reset, above everything else): on the flush edge:
  - out_valid=0, state=IDLE, busy=0, counter=0.
  - No accept that cycle.
  - alu_result/rd_out keep their old values (don't-care).
- Reset mid-multiply: identical to flush plus alu_result/rd_out cleared.
- Simultaneous out_ready and new accept: old result consumed and new one registered on the same edge; out_valid stays 1.

Optional Feature:
- Macro: ALU_FAST_MUL_EN.
- Defined: multiplies use a combinational 2*XLEN product and complete in one cycle like other ops; MUL/DONE states unused; busy tied 0.
- Undefined: iterative XLEN-cycle multiplier as above.

Test Plan:
- ADD aluin1=5, aluin2=7, rd_in=3, out_ready=1 -> out_valid next edge, alu_result=12, rd_out=3; SUB 5-7 -> 0xFFFFFFFE.
- SRA 0x80000000 by aluin2=0x24 -> 0xF8000000 (only 4 used); SLT -1<1 -> 1; SLTU 0xFFFFFFFF<1 -> 0.
- MUL -2*3 -> 0xFFFFFFFA; MULH -2*3 -> 0xFFFFFFFF; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
  - Each arrives 32 cycles after accept; busy=1 and in_ready=0 throughout.
  - With ALU_FAST_MUL_EN: 1 cycle.
- Backpressure: ADD result with out_ready=0 for 5 cycles -> result/rd_out stable, in_ready=0; release -> consumed, in_ready=1 same cycle.
- Flush at cycle 10 of a MUL -> busy=0, out_valid=0 next edge, no result emitted; following ADD 1+1 -> 2 with latency 1.
- Reset asserted with out_valid=1 and during a MUL -> all outputs 0, state IDLE, in_ready=1 after reset deasserts.
